// File: rtl/gate_controller.sv
// Parking-gate controller: an arrival sensor starts a PIN entry session, a
// correct PIN opens the gate, and the post-gate sensor closes it once the
// vehicle has passed. Repeated wrong PINs raise p_alarm. A vehicle on both
// sensors at once (tailgating) locks the gate and raises b_alarm.
module gate_controller #(
    parameter logic [7:0] PASSWORD     = 8'b00101010,
    parameter int         MAX_ATTEMPTS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       asensor,
    input  logic       lsensor,
    input  logic       enter,
    input  logic [7:0] password,
    output logic       p_alarm,
    output logic       b_alarm,
    output logic       gate_open,
    output logic       gate_close,
    output logic       gate_block
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [AW-1:0] MAX_A = AW'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PIN  = 3'd1,
        PIN_ALARM = 3'd2,
        OPEN      = 3'd3,
        BLOCK     = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] attempts, attempts_nxt;
    logic          enter_q, lsensor_q;
    logic          ent, lfall, pin_ok;

    // One entry event per enter strobe, however long it is held; lsensor
    // falling means the vehicle has cleared the post-gate sensor.
    assign ent    = enter & ~enter_q;
    assign lfall  = ~lsensor & lsensor_q;
    assign pin_ok = (password == PASSWORD);

    // State, attempt counter, edge-detect history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            attempts   <= '0;
            enter_q    <= 1'b0;
            lsensor_q  <= 1'b0;
            p_alarm    <= 1'b0;
            b_alarm    <= 1'b0;
            gate_open  <= 1'b0;
            gate_close <= 1'b1;
            gate_block <= 1'b0;
        end else begin
            state      <= state_nxt;
            attempts   <= attempts_nxt;
            enter_q    <= enter;
            lsensor_q  <= lsensor;
            // Moore decode of the next state, so outputs move on the same
            // edge that samples the causing input.
            p_alarm    <= (state_nxt == PIN_ALARM);
            b_alarm    <= (state_nxt == BLOCK);
            gate_block <= (state_nxt == BLOCK);
            gate_open  <= (state_nxt == OPEN);
            gate_close <= (state_nxt != OPEN);
        end
    end

    // Next-state and attempt-counter logic; tailgating overrides everything
    // outside IDLE.
    always_comb begin
        state_nxt    = state;
        attempts_nxt = attempts;
        if (state != IDLE && asensor && lsensor) begin
            state_nxt = BLOCK;
        end else begin
            case (state)
                IDLE: begin
                    if (asensor) state_nxt = WAIT_PIN;
                end
                WAIT_PIN: begin
                    // An entry on the same edge as asensor dropping is
                    // evaluated and its result takes precedence.
                    if (ent) begin
                        if (pin_ok) begin
                            state_nxt    = OPEN;
                            attempts_nxt = '0;
                        end else begin
                            attempts_nxt = attempts + 1'b1;
                            if (attempts_nxt >= MAX_A) state_nxt = PIN_ALARM;
                        end
                    end else if (!asensor) begin
                        state_nxt    = IDLE;
                        attempts_nxt = '0;
                    end
                end
                PIN_ALARM: begin
                    // Counter already sits at MAX_A; wrong PINs leave it there.
                    if (ent && pin_ok) begin
                        state_nxt    = OPEN;
                        attempts_nxt = '0;
                    end
                end
                OPEN: begin
                    if (lfall && !asensor) state_nxt = IDLE;
                end
                BLOCK: begin
                    // Only a correct PIN with the post-gate sensor clear unlocks.
                    if (ent && pin_ok && !lsensor) begin
                        state_nxt    = IDLE;
                        attempts_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    attempts_nxt = '0;
                end
            endcase
        end
    end

endmodule
